spixif: RTL and testbench
=========================

SPIXIF -- requirements
Module: SPIxIF

Interface
REQ-001 SHALL have port Clk, input, 1: single system clock, all logic on rising edge.
REQ-002 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port LSB, input, 1: bit order; 1 = LSB first, 0 = MSB first.
REQ-004 SHALL have port Mode, input, 2: SPI mode; Mode[0] = SCK idle level (CPOL), Mode[1] = launch on first edge (CPHA).
REQ-005 SHALL have port Rate, input, 3: SCK half-period = 2^Rate Clk cycles.
REQ-006 SHALL have port DAV, input, 1: transmit FIFO not empty.
REQ-007 SHALL have port FRE, output, 1: transmit FIFO read strobe, one Clk wide.
REQ-008 SHALL have port TD, input, 9: TD[7:0] = byte to send; TD[8] = last byte of frame.
REQ-009 SHALL have port FWE, output, 1: receive FIFO write strobe, one Clk wide.
REQ-010 SHALL have port RD, output, 8: received byte, valid while FWE = 1.
REQ-011 SHALL have port SS, output, 1: slave select, active high for the whole frame.
REQ-012 SHALL have ports SCK (output), MOSI (output) and MISO (input), 1 bit each: SPI bus.

Function
REQ-013 SHALL, while idle with DAV = 1, pulse FRE for one cycle, capture TD on that edge, assert SS and start a frame.
REQ-014 SHALL sample Mode, Rate and LSB at frame start and hold them constant until SS falls.
REQ-015 SHALL shift 8 bits per byte, with each byte lasting exactly 16*2^Rate Clk cycles; SS high time = bytes*16*2^Rate cycles (no inter-byte gap).
REQ-016 SHALL, with CPHA = 0, present the first bit on MOSI at SS rise with SCK at idle level; the first SCK edge samples MISO.
REQ-017 SHALL, with CPHA = 1, drive the first SCK edge (to non-idle) in the first cycle after FRE; that edge launches the bit, and the second edge samples it.
REQ-018 SHALL, at the end of each byte, pulse FWE for one cycle with RD = received byte (loopback MOSI->MISO gives RD = TD[7:0]).
REQ-019 SHALL, at the end of a byte with TD[8] = 0 and DAV = 1, pulse FRE in the last cycle of the byte and continue without a gap.
REQ-020 SHALL deassert SS after the byte if TD[8] = 1 or DAV = 0, and return to idle.
REQ-021 SHALL, while idle, register SCK to Mode[0] each Clk (one-cycle lag after a Mode change) and hold MOSI at 0.
REQ-022 SHALL accept DAV dropping at the FRE edge and not issue an extra FRE.
REQ-023 SHALL implement a state machine with states IDLE -> XFER (8 bits) -> {XFER on continue | IDLE on end}.

Reset
REQ-024 SHALL, while Rst = 1 (immediately, asynchronous), force SS = 0, SCK = 0, MOSI = 0, FRE = 0, FWE = 0, RD = 0, state = IDLE and the prescaler/bit counter = 0.
REQ-025 SHALL, on Rst asserted mid-frame, abort the frame with no FWE; the next frame starts only from IDLE.

Configuration
REQ-026 SHALL, with SPIXIF_LSB_EN defined, honour LSB for bit order on both MOSI and RD.
REQ-027 SHALL, without SPIXIF_LSB_EN, always transfer MSB first and ignore LSB.

Structure
REQ-028 SHALL define in shared package spixif_pkg: the mode bit positions, state encoding, 3-bit rate width and 8-bit data width.
REQ-029 SHALL use one sub-module spixif_sck_gen: a 2^Rate prescaler that emits SCK edge enables and the bit count.

Verification
REQ-030 SHALL verify: Mode 0, Rate 0, TD = 1AB -> SCK idle 0, start 0, RD = AB, SS high 16 cycles.
REQ-031 SHALL verify: Modes 1/2/3 with TD = 15A/1A5/169 -> idle SCK 1/0/1, SCK 1/1/0 after FRE, RD = 5A/A5/69, SS high 16 cycles each.
REQ-032 SHALL verify: Rate 0, DAV held high, TD = 002, 000, 0AA, 055, then DAV = 0 -> four FRE pulses, SS high 64 cycles.
REQ-033 SHALL verify: the same 4-byte frame at Rate = 1..7 -> SS high 128, 256, 512, 1024, 2048, 4096, 8192 cycles.
REQ-034 SHALL verify: LSB = 1 (macro on), TD = 101 -> MOSI first bit 1, RD = 01; with macro off, the same stimulus sends MSB first.
REQ-035 SHALL verify: Rst pulse mid-frame -> SS = 0 and SCK = 0 immediately, no FWE.

Source files
------------

// File: rtl/spixif_pkg.sv
// Shared definitions for the SPI master interface: mode bit positions, state encoding,
// field widths and a bit-order helper.
package spixif_pkg;

  localparam int unsigned ModeCpol = 0;  // Mode bit holding the SCK idle level
  localparam int unsigned ModeCpha = 1;  // Mode bit selecting launch on first edge
  localparam int unsigned RateW    = 3;
  localparam int unsigned DataW    = 8;
  localparam int unsigned PreW     = 7;  // holds 2^7-1, the longest half-period count

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } state_e;

  // Bit that goes out first for the selected order.
  function automatic logic first_bit(input logic [DataW-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DataW-1];
  endfunction

endpackage

// File: rtl/spixif_sck_gen.sv
// SCK timing for spixif: a 2^rate prescaler producing one tick per SCK half-period and
// a count of half-periods completed within the current byte (0..15).
module spixif_sck_gen
  import spixif_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [RateW-1:0] i_rate,
  output logic             o_tick,
  output logic [3:0]       o_half
);

  logic [PreW-1:0] r_pre;
  logic [3:0]      r_half;
  logic [PreW-1:0] w_pre_max;

  assign w_pre_max = PreW'((8'd1 << i_rate) - 8'd1);
  // A tick marks the Clk edge on which the next SCK half-period boundary falls.
  assign o_tick    = i_run && (r_pre == w_pre_max);
  assign o_half    = r_half;

  // Prescaler and half-period counter; held at zero while not transferring.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre  <= '0;
      r_half <= '0;
    end else if (!i_run) begin
      r_pre  <= '0;
      r_half <= '0;
    end else if (o_tick) begin
      r_pre  <= '0;
      r_half <= r_half + 4'd1;  // wraps to 0 at the byte boundary
    end else begin
      r_pre  <= r_pre + PreW'(1);
    end
  end

endmodule

// File: rtl/spixif.sv
// SPI master between a transmit FIFO (TD/DAV/FRE) and a receive FIFO (RD/FWE).
// Optional feature: define SPIXIF_LSB_EN to honour LSB for bit order; otherwise MSB first.
module spixif
  import spixif_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             LSB,
  input  logic [1:0]       Mode,
  input  logic [RateW-1:0] Rate,
  input  logic             DAV,
  output logic             FRE,
  input  logic [8:0]       TD,
  output logic             FWE,
  output logic [DataW-1:0] RD,
  output logic             SS,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO
);

  state_e           r_state, w_state_d;
  logic             r_cpol, r_cpha, r_lsb, r_last;
  logic [RateW-1:0] r_rate;
  logic [DataW-1:0] r_tx, r_rx, r_rd;
  logic             r_fwe, r_ss, r_sck, r_mosi;

  logic             w_tick, w_fre, w_load, w_start, w_stop, w_end_byte;
  logic             w_sample, w_launch, w_toggle, w_lsb_in;
  logic [3:0]       w_half;
  logic [DataW-1:0] w_tx_sh;

`ifdef SPIXIF_LSB_EN
  assign w_lsb_in = LSB;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = LSB;
  assign w_lsb_in     = 1'b0;
`endif

  spixif_sck_gen u_sck_gen (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_run  (r_state == StXfer),
    .i_rate (r_rate),
    .o_tick (w_tick),
    .o_half (w_half)
  );

  // Half-period k = w_half+1 ends on this tick: odd k samples, even k (2..14) launches,
  // k = 16 closes the byte.
  assign w_end_byte = w_tick && (w_half == 4'd15);
  assign w_sample   = w_tick && !w_half[0];
  assign w_launch   = w_tick && w_half[0] && (w_half != 4'd15);
  assign w_toggle   = w_tick && (w_half != 4'd15);
  assign w_tx_sh    = r_lsb ? {1'b0, r_tx[DataW-1:1]} : {r_tx[DataW-2:0], 1'b0};

  // Frame state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next state and FIFO read strobe: start from idle, chain bytes, or close the frame.
  always_comb begin
    w_state_d = r_state;
    w_fre     = 1'b0;
    w_load    = 1'b0;
    w_start   = 1'b0;
    w_stop    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (DAV) begin
          w_fre     = 1'b1;
          w_load    = 1'b1;
          w_start   = 1'b1;
          w_state_d = StXfer;
        end
      end
      StXfer: begin
        if (w_end_byte) begin
          if (!r_last && DAV) begin
            w_fre  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_stop    = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Shift datapath, bus pins and receive strobe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
      r_last <= 1'b0;
      r_rate <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_rd   <= '0;
      r_fwe  <= 1'b0;
      r_ss   <= 1'b0;
      r_sck  <= 1'b0;
      r_mosi <= 1'b0;
    end else begin
      r_fwe <= 1'b0;
      // Configuration is frozen for the whole frame.
      if (w_start) begin
        r_cpol <= Mode[ModeCpol];
        r_cpha <= Mode[ModeCpha];
        r_rate <= Rate;
        r_lsb  <= w_lsb_in;
      end
      if (w_load) begin
        r_tx   <= TD[DataW-1:0];
        r_last <= TD[8];
        r_ss   <= 1'b1;
        r_mosi <= first_bit(TD[DataW-1:0], w_start ? w_lsb_in : r_lsb);
        // CPHA=1 makes its first (launch) edge here; CPHA=0 starts at idle level.
        r_sck  <= w_start ? (Mode[ModeCpol] ^ Mode[ModeCpha]) : (r_cpol ^ r_cpha);
      end else if (w_stop) begin
        r_ss   <= 1'b0;
        r_mosi <= 1'b0;
        r_sck  <= r_cpol;
      end else if (r_state == StIdle) begin
        r_sck  <= Mode[ModeCpol];
      end else begin
        if (w_sample) r_rx <= r_lsb ? {MISO, r_rx[DataW-1:1]} : {r_rx[DataW-2:0], MISO};
        if (w_launch) begin
          r_tx   <= w_tx_sh;
          r_mosi <= first_bit(w_tx_sh, r_lsb);
        end
        if (w_toggle) r_sck <= ~r_sck;
      end
      if (w_end_byte) begin
        r_fwe <= 1'b1;
        r_rd  <= r_rx;
      end
    end
  end

  assign FRE  = w_fre;
  assign FWE  = r_fwe;
  assign RD   = r_rd;
  assign SS   = r_ss;
  assign SCK  = r_sck;
  assign MOSI = r_mosi;

endmodule

// File: tb/tb_spixif.sv
// Directed bench for spixif with MOSI looped back to MISO.
module tb_spixif;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       LSB = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic [2:0] Rate = 3'd0;
  logic       DAV = 1'b0;
  logic [8:0] TD = 9'd0;
  logic       FRE, FWE, SS, SCK, MOSI, MISO;
  logic [7:0] RD;

  int n_pass = 0;
  int n_total = 0;

  logic [8:0] tx_q [4];
  logic [7:0] rd_log [4];
  int   ss_cyc, fre_cnt, fwe_cnt;
  logic sck_first, mosi_first;

  assign MISO = MOSI;
  always #5 Clk = ~Clk;

  spixif u_dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .LSB  (LSB),
    .Mode (Mode),
    .Rate (Rate),
    .DAV  (DAV),
    .FRE  (FRE),
    .TD   (TD),
    .FWE  (FWE),
    .RD   (RD),
    .SS   (SS),
    .SCK  (SCK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  // Feed n bytes from tx_q, sampling outputs mid-cycle until the frame and its last FWE end.
  task automatic run_frame(input int n, input int limit);
    int idx;
    bit prev_fre, started, done, got_first;
    ss_cyc = 0; fre_cnt = 0; fwe_cnt = 0;
    idx = 0; prev_fre = 0; started = 0; done = 0; got_first = 0;
    sck_first = 1'bx; mosi_first = 1'bx;
    TD = tx_q[0];
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge Clk);
      if (c == 0) DAV = 1'b1;
      if (prev_fre) begin
        if (!got_first) begin
          sck_first = SCK; mosi_first = MOSI; got_first = 1;
        end
        idx++;
        if (idx < n) TD = tx_q[idx];
        else DAV = 1'b0;
      end
      #1;
      prev_fre = FRE;
      if (FRE) begin fre_cnt++; started = 1; end
      if (SS) ss_cyc++;
      if (FWE) begin
        if (fwe_cnt < 4) rd_log[fwe_cnt] = RD;
        fwe_cnt++;
      end
      if (started && !FRE && !SS && !FWE && c > 1) done = 1;
    end
    DAV = 1'b0;
    n_total++;
    if (!done) $display("FAIL frame_timeout: frame still running after %0d cycles, required end", limit);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (SS !== 1'b0) $display("FAIL rst_ss: got %b want 0", SS); else n_pass++;
    n_total++; if (SCK !== 1'b0) $display("FAIL rst_sck: got %b want 0", SCK); else n_pass++;
    n_total++; if (MOSI !== 1'b0) $display("FAIL rst_mosi: got %b want 0", MOSI); else n_pass++;
    n_total++; if (FRE !== 1'b0) $display("FAIL rst_fre: got %b want 0", FRE); else n_pass++;
    n_total++; if (FWE !== 1'b0) $display("FAIL rst_fwe: got %b want 0", FWE); else n_pass++;
    n_total++; if (RD !== 8'h00) $display("FAIL rst_rd: got %h want 00", RD); else n_pass++;
    Mode = 2'd1;  // idle-high mode must not leak onto SCK while reset is held
    @(posedge Clk); #1;
    n_total++; if (SCK !== 1'b0) $display("FAIL rst_sck_hold: got %b want 0", SCK); else n_pass++;
    @(negedge Clk);
    Rst = 1'b0;
    Mode = 2'd0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_mode(input logic [1:0] m, input logic [8:0] td, input logic exp_idle,
                           input logic exp_after, input logic exp_mosi, input logic [7:0] exp_rd);
    Mode = m; Rate = 3'd0; LSB = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    n_total++;
    if (SCK !== exp_idle) $display("FAIL mode%0d_idle_sck: got %b want %b", m, SCK, exp_idle);
    else n_pass++;
    tx_q[0] = td;
    run_frame(1, 60);
    n_total++;
    if (fre_cnt !== 1) $display("FAIL mode%0d_fre: got %0d want 1", m, fre_cnt); else n_pass++;
    n_total++;
    if (sck_first !== exp_after)
      $display("FAIL mode%0d_sck_after_fre: got %b want %b", m, sck_first, exp_after);
    else n_pass++;
    n_total++;
    if (mosi_first !== exp_mosi)
      $display("FAIL mode%0d_first_mosi: got %b want %b", m, mosi_first, exp_mosi);
    else n_pass++;
    n_total++;
    if (ss_cyc !== 16) $display("FAIL mode%0d_ss_len: got %0d want 16", m, ss_cyc); else n_pass++;
    n_total++;
    if (fwe_cnt !== 1) $display("FAIL mode%0d_fwe: got %0d want 1", m, fwe_cnt); else n_pass++;
    n_total++;
    if (rd_log[0] !== exp_rd) $display("FAIL mode%0d_rd: got %h want %h", m, rd_log[0], exp_rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h02, 8'h00, 8'hAA, 8'h55};
    Mode = 2'd0; Rate = 3'd0; LSB = 1'b0;
    tx_q = '{9'h002, 9'h000, 9'h0AA, 9'h055};
    repeat (2) @(negedge Clk);
    run_frame(4, 100);
    n_total++; if (fre_cnt !== 4) $display("FAIL b2b_fre: got %0d want 4", fre_cnt); else n_pass++;
    n_total++; if (ss_cyc !== 64) $display("FAIL b2b_ss_len: got %0d want 64", ss_cyc); else n_pass++;
    n_total++; if (fwe_cnt !== 4) $display("FAIL b2b_fwe: got %0d want 4", fwe_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (rd_log[i] !== exp_rd[i]) $display("FAIL b2b_rd%0d: got %h want %h", i, rd_log[i], exp_rd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rates();
    int exp_ss [7];
    exp_ss = '{128, 256, 512, 1024, 2048, 4096, 8192};
    Mode = 2'd0; LSB = 1'b0;
    for (int r = 1; r <= 7; r++) begin
      Rate = 3'(r);
      tx_q = '{9'h002, 9'h000, 9'h0AA, 9'h055};
      repeat (2) @(negedge Clk);
      run_frame(4, exp_ss[r-1] + 40);
      n_total++;
      if (ss_cyc !== exp_ss[r-1]) $display("FAIL rate%0d_ss_len: got %0d want %0d", r, ss_cyc, exp_ss[r-1]);
      else n_pass++;
      n_total++;
      if (rd_log[3] !== 8'h55) $display("FAIL rate%0d_rd: got %h want 55", r, rd_log[3]);
      else n_pass++;
    end
    Rate = 3'd0;
  endtask

  task automatic test_lsb();
    logic exp_first;
`ifdef SPIXIF_LSB_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    Mode = 2'd0; Rate = 3'd0; LSB = 1'b1;
    tx_q[0] = 9'h101;
    repeat (2) @(negedge Clk);
    run_frame(1, 60);
    n_total++;
    if (mosi_first !== exp_first) $display("FAIL lsb_first_mosi: got %b want %b", mosi_first, exp_first);
    else n_pass++;
    n_total++;
    if (rd_log[0] !== 8'h01) $display("FAIL lsb_rd: got %h want 01", rd_log[0]); else n_pass++;
    LSB = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fwe_seen;
    bit ss_up;
    Mode = 2'd1; Rate = 3'd2; LSB = 1'b0;
    repeat (3) @(negedge Clk);
    TD = 9'h1C3; DAV = 1'b1;
    ss_up = 0;
    for (int c = 0; c < 10 && !ss_up; c++) begin
      @(negedge Clk); #1;
      if (SS) ss_up = 1;
    end
    DAV = 1'b0;
    n_total++; if (!ss_up) $display("FAIL mid_ss_rise: got 0 want 1"); else n_pass++;
    repeat (20) @(negedge Clk);
    fwe_seen = 0;
    #2 Rst = 1'b1;
    #1;
    n_total++; if (SS !== 1'b0) $display("FAIL mid_rst_ss: got %b want 0", SS); else n_pass++;
    n_total++; if (SCK !== 1'b0) $display("FAIL mid_rst_sck: got %b want 0", SCK); else n_pass++;
    n_total++; if (MOSI !== 1'b0) $display("FAIL mid_rst_mosi: got %b want 0", MOSI); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk); #1;
      if (FWE) fwe_seen++;
    end
    Rst = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge Clk); #1;
      if (FWE) fwe_seen++;
    end
    n_total++; if (fwe_seen !== 0) $display("FAIL mid_rst_fwe: got %0d want 0", fwe_seen); else n_pass++;
    n_total++; if (SS !== 1'b0) $display("FAIL mid_rst_idle_ss: got %b want 0", SS); else n_pass++;
    n_total++; if (RD !== 8'h00) $display("FAIL mid_rst_rd: got %h want 00", RD); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode(2'd0, 9'h1AB, 1'b0, 1'b0, 1'b1, 8'hAB);
    test_mode(2'd1, 9'h15A, 1'b1, 1'b1, 1'b0, 8'h5A);
    test_mode(2'd2, 9'h1A5, 1'b0, 1'b1, 1'b1, 8'hA5);
    test_mode(2'd3, 9'h169, 1'b1, 1'b0, 1'b0, 8'h69);
    test_back_to_back();
    test_rates();
    test_lsb();
    test_reset_mid();
    test_mode(2'd1, 9'h15A, 1'b1, 1'b1, 1'b0, 8'h5A);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
